// File: rtl/irq_ctrl_if.sv
// ----------------------------------------------------------------------------
// irq_ctrl_if
//
// Purpose: bundles the interrupt request / dispatch signals between the
// peripheral side (request sources, mask, end-of-interrupt from the core)
// and the interrupt controller.
//
// Signals:
//   src      raw interrupt requests, may be asynchronous      (master -> slave)
//   mask     1 = source enabled for dispatch                  (master -> slave)
//   eoi      single-cycle end-of-interrupt pulse from core    (master -> slave)
//   irq      one-hot 32-bit interrupt vector to the core      (slave -> master)
//   irq_id   index of the source in service                   (slave -> master)
//   active   an interrupt is in service                       (slave -> master)
//   pending  pending register, for debug                      (slave -> master)
// ----------------------------------------------------------------------------
interface irq_ctrl_if #(
    parameter int NUM_SRC = 7
);
    logic [NUM_SRC-1:0] src;
    logic [NUM_SRC-1:0] mask;
    logic               eoi;
    logic [31:0]        irq;
    logic [4:0]         irq_id;
    logic               active;
    logic [NUM_SRC-1:0] pending;

    modport master (
        output src, mask, eoi,
        input  irq, irq_id, active, pending
    );

    modport slave (
        input  src, mask, eoi,
        output irq, irq_id, active, pending
    );
endinterface

// File: rtl/irq_ctrl.sv
// ----------------------------------------------------------------------------
// irq_ctrl
//
// Purpose: interrupt controller for the peripherals subsystem. Synchronises
// NUM_SRC request lines, latches them as pending (edge or level mode per
// source), and dispatches one interrupt at a time by fixed priority (lowest
// index wins) onto bit IRQ_BASE+k of the core's irq vector. The dispatched
// line is held until the core pulses eoi.
//
// Ports:
//   clk    system clock, the only clock
//   reset  synchronous, active-high reset
//   bus    irq_ctrl_if slave modport: src/mask/eoi in, irq/irq_id/active/
//          pending out
//
// Parameters:
//   NUM_SRC    number of interrupt sources (1..16)
//   IRQ_BASE   irq bit driven by source 0; IRQ_BASE+NUM_SRC <= 32
//   LEVEL_SRC  per-source mode: 1 = level, 0 = rising-edge
// ----------------------------------------------------------------------------
module irq_ctrl #(
    parameter int                 NUM_SRC   = 7,
    parameter int                 IRQ_BASE  = 16,
    parameter logic [NUM_SRC-1:0] LEVEL_SRC = '0
) (
    input  logic      clk,
    input  logic      reset,
    irq_ctrl_if.slave bus
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t             state_q;
    logic [NUM_SRC-1:0] sync1_q;
    logic [NUM_SRC-1:0] sync2_q;     // synchronised request (s2)
    logic [NUM_SRC-1:0] hist_q;      // s2 from the previous cycle
    logic [NUM_SRC-1:0] pending_q;
    logic [NUM_SRC-1:0] pending_d;
    logic [31:0]        irq_q;
    logic [4:0]         irq_id_q;
    logic               active_q;

    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] edge_set;
    logic [NUM_SRC-1:0] clr_mask;
    logic [4:0]         win_idx;
    logic               dispatch;

    assign eligible = pending_q & bus.mask;
    assign dispatch = (state_q == IDLE) && (|eligible);
    assign edge_set = sync2_q & ~hist_q;

    // Lowest eligible index wins: scan downward so the last hit is the lowest.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        win_idx = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (eligible[k]) begin
                win_idx = 5'(k);
            end
        end
    end

    // Dispatch clears only the winning edge-mode bit; a new edge in the same
    // cycle still sets it (set wins). Level-mode bits simply follow s2.
    always_comb begin
        clr_mask  = dispatch ? (NUM_SRC'(1) << win_idx) : '0;
        pending_d = (LEVEL_SRC & sync2_q)
                  | (~LEVEL_SRC & (edge_set | (pending_q & ~clr_mask)));
    end

    // Synchroniser, edge history and pending register.
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            hist_q    <= '0;
            pending_q <= '0;
        end else begin
            sync1_q   <= bus.src;
            sync2_q   <= sync1_q;
            hist_q    <= sync2_q;
            pending_q <= pending_d;
        end
    end

    // Dispatch FSM with registered outputs. The winner is latched on the same
    // edge that enters ACTIVE; mask changes during ACTIVE are not looked at.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            irq_q    <= '0;
            irq_id_q <= '0;
            active_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (dispatch) begin
                        state_q  <= ACTIVE;
                        irq_q    <= 32'(1) << (IRQ_BASE + int'(win_idx));
                        irq_id_q <= win_idx;
                        active_q <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (bus.eoi) begin
                        state_q  <= IDLE;
                        irq_q    <= '0;
                        active_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    irq_q    <= '0;
                    active_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.irq     = irq_q;
    assign bus.irq_id  = irq_id_q;
    assign bus.active  = active_q;
    assign bus.pending = pending_q;

endmodule
